// File: rtl/rv32_exec_datapath_if.sv
// Execute-datapath bus: register-file ports plus ALU operands and results.
// master = core sequencer side, slave = datapath side.
interface rv32_exec_datapath_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [ADDR_W-1:0] write_reg;
  logic [31:0]       write_data;
  logic              write_en;
  logic [31:0]       data_out_1;
  logic [31:0]       data_out_2;
  logic [31:0]       alu_in1;
  logic [31:0]       alu_in2;
  logic [3:0]        alu_control;
  logic [31:0]       alu_out;
  logic              alu_zero;
  logic              alu_neg;

  modport master (
    output read_reg_1, read_reg_2, write_reg, write_data, write_en,
    output alu_in1, alu_in2, alu_control,
    input  data_out_1, data_out_2, alu_out, alu_zero, alu_neg
  );

  modport slave (
    input  read_reg_1, read_reg_2, write_reg, write_data, write_en,
    input  alu_in1, alu_in2, alu_control,
    output data_out_1, data_out_2, alu_out, alu_zero, alu_neg
  );
endinterface

// File: rtl/rv32_exec_datapath.sv
// RV32I execute datapath: 2R/1W register file beside a combinational ALU.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module rv32_exec_datapath #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ZERO_R0 = 1
) (
  input logic                 clk,
  input logic                 reset,
  rv32_exec_datapath_if.slave dp
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [31:0] regs_q [NumRegs];
  logic        wr_drop;
  logic        wr_fire;
  logic [31:0] rd_1;
  logic [31:0] rd_2;

  assign wr_drop = (ZERO_R0 != 0) && (dp.write_reg == '0);
  assign wr_fire = dp.write_en && !reset && !wr_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      regs_q[dp.write_reg] <= dp.write_data;
    end
  end

  always_comb begin
    rd_1 = regs_q[dp.read_reg_1];
    rd_2 = regs_q[dp.read_reg_2];
    if ((ZERO_R0 != 0) && (dp.read_reg_1 == '0)) rd_1 = '0;
    if ((ZERO_R0 != 0) && (dp.read_reg_2 == '0)) rd_2 = '0;
  end

`ifdef RF_BYPASS_EN
  // wr_fire already excludes reset and dropped x0 writes.
  always_comb begin
    dp.data_out_1 = rd_1;
    dp.data_out_2 = rd_2;
    if (wr_fire && (dp.read_reg_1 == dp.write_reg)) dp.data_out_1 = dp.write_data;
    if (wr_fire && (dp.read_reg_2 == dp.write_reg)) dp.data_out_2 = dp.write_data;
  end
`else
  assign dp.data_out_1 = rd_1;
  assign dp.data_out_2 = rd_2;
`endif

  logic [31:0] alu_res;
  logic [4:0]  shamt;

  assign shamt = dp.alu_in2[4:0];

  always_comb begin
    alu_res = '0;
    case (dp.alu_control)
      4'b0000: alu_res = dp.alu_in1 + dp.alu_in2;
      4'b1000: alu_res = dp.alu_in1 - dp.alu_in2;
      4'b0001: alu_res = dp.alu_in1 << shamt;
      4'b0101: alu_res = dp.alu_in1 >> shamt;
      4'b1101: alu_res = $unsigned($signed(dp.alu_in1) >>> shamt);
      4'b0010: alu_res = {31'd0, $signed(dp.alu_in1) < $signed(dp.alu_in2)};
      4'b0011: alu_res = {31'd0, dp.alu_in1 < dp.alu_in2};
      4'b0100: alu_res = dp.alu_in1 ^ dp.alu_in2;
      4'b0110: alu_res = dp.alu_in1 | dp.alu_in2;
      4'b0111: alu_res = dp.alu_in1 & dp.alu_in2;
      default: alu_res = '0;
    endcase
  end

  assign dp.alu_out  = alu_res;
  assign dp.alu_zero = (alu_res == '0);
  assign dp.alu_neg  = alu_res[31];

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// Directed bench for rv32_exec_datapath; expectations follow RF_BYPASS_EN when defined.
module tb_rv32_exec_datapath;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  rv32_exec_datapath_if #(.ADDR_W(5)) dp_if ();

  rv32_exec_datapath #(
    .ADDR_W (5),
    .ZERO_R0(1)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .dp   (dp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
    dp_if.alu_in1     = a;
    dp_if.alu_in2     = b;
    dp_if.alu_control = ctl;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset                = 1'b1;
    dp_if.read_reg_1     = '0;
    dp_if.read_reg_2     = '0;
    dp_if.write_reg      = 5'd3;
    dp_if.write_data     = 32'hFFFF_FFFF;
    dp_if.write_en       = 1'b1;
    dp_if.alu_in1        = '0;
    dp_if.alu_in2        = '0;
    dp_if.alu_control    = '0;
    tick();
    reset          = 1'b0;
    dp_if.write_en = 1'b0;

    // Reset state: every register reads 0 on both ports.
    for (int i = 0; i < 32; i++) begin
      dp_if.read_reg_1 = 5'(i);
      dp_if.read_reg_2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1_r%0d", i), dp_if.data_out_1, 32'h0);
      check($sformatf("reset_rd2_r%0d", 31 - i), dp_if.data_out_2, 32'h0);
    end

    // Write r5, attempt write to r0.
    dp_if.write_en   = 1'b1;
    dp_if.write_reg  = 5'd5;
    dp_if.write_data = 32'hDEAD_BEEF;
    tick();
    dp_if.write_reg  = 5'd0;
    dp_if.write_data = 32'h0000_1234;
    tick();
    dp_if.write_en   = 1'b0;
    dp_if.read_reg_1 = 5'd5;
    dp_if.read_reg_2 = 5'd0;
    #1;
    check("wr_r5", dp_if.data_out_1, 32'hDEAD_BEEF);
    check("wr_r0_dropped", dp_if.data_out_2, 32'h0);

    // ALU
    alu(32'h7FFF_FFFF, 32'd1, 4'b0000);
    check("add_ovf", dp_if.alu_out, 32'h8000_0000);
    check("add_neg", 32'(dp_if.alu_neg), 32'd1);
    check("add_zero", 32'(dp_if.alu_zero), 32'd0);
    alu(32'd5, 32'd5, 4'b1000);
    check("sub_eq", dp_if.alu_out, 32'h0);
    check("sub_zero", 32'(dp_if.alu_zero), 32'd1);
    check("sub_neg", 32'(dp_if.alu_neg), 32'd0);
    alu(32'd0, 32'd1, 4'b1000);
    check("sub_wrap", dp_if.alu_out, 32'hFFFF_FFFF);
    alu(32'h8000_0000, 32'h24, 4'b1101);
    check("sra", dp_if.alu_out, 32'hF800_0000);
    alu(32'h8000_0000, 32'h24, 4'b0101);
    check("srl", dp_if.alu_out, 32'h0800_0000);
    alu(32'h8000_0000, 32'h24, 4'b0001);
    check("sll_out", dp_if.alu_out, 32'h0);
    alu(32'h0000_0003, 32'hFFFF_FFE1, 4'b0001);
    check("sll_b_high_ignored", dp_if.alu_out, 32'h0000_0006);
    alu(32'hFFFF_FFFF, 32'd1, 4'b0010);
    check("slt", dp_if.alu_out, 32'd1);
    alu(32'hFFFF_FFFF, 32'd1, 4'b0011);
    check("sltu", dp_if.alu_out, 32'd0);
    alu(32'd1, 32'hFFFF_FFFF, 4'b0011);
    check("sltu_true", dp_if.alu_out, 32'd1);
    alu(32'hFFFF_FFFF, 32'd1, 4'b1111);
    check("undef_1111", dp_if.alu_out, 32'd0);
    check("undef_zero", 32'(dp_if.alu_zero), 32'd1);
    alu(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0100);
    check("xor", dp_if.alu_out, 32'hFF00_EDCB);
    alu(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0110);
    check("or", dp_if.alu_out, 32'hFFF0_FFFF);
    alu(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0111);
    check("and", dp_if.alu_out, 32'h00F0_1234);
    alu(32'h1234_5678, 32'h1, 4'b1010);
    check("undef_1010", dp_if.alu_out, 32'd0);

    // Read during write to r7 (old value 0x11).
    dp_if.write_en   = 1'b1;
    dp_if.write_reg  = 5'd7;
    dp_if.write_data = 32'h11;
    tick();
    dp_if.write_data = 32'hA5;
    dp_if.read_reg_1 = 5'd7;
    #1;
`ifdef RF_BYPASS_EN
    check("rdw_before_edge", dp_if.data_out_1, 32'hA5);
`else
    check("rdw_before_edge", dp_if.data_out_1, 32'h11);
`endif
    tick();
    dp_if.write_en = 1'b0;
    #1;
    check("rdw_after_edge", dp_if.data_out_1, 32'hA5);

    // Dropped x0 write is never forwarded.
    dp_if.write_en   = 1'b1;
    dp_if.write_reg  = 5'd0;
    dp_if.write_data = 32'hFFFF;
    dp_if.read_reg_2 = 5'd0;
    #1;
    check("x0_no_fwd", dp_if.data_out_2, 32'h0);

    // Write concurrent with reset: no forwarding, no store, contents cleared.
    dp_if.write_reg  = 5'd7;
    dp_if.write_data = 32'h5A;
    reset            = 1'b1;
    #1;
    check("reset_no_fwd", dp_if.data_out_1, 32'hA5);
    tick();
    reset          = 1'b0;
    dp_if.write_en = 1'b0;
    dp_if.read_reg_2 = 5'd5;
    #1;
    check("reset_r7_clear", dp_if.data_out_1, 32'h0);
    check("reset_r5_clear", dp_if.data_out_2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
